// File: rtl/cv32e40p_irq_arbiter.sv
// rtl/cv32e40p_irq_arbiter.sv - interrupt arbiter with level/edge lines, priority, threshold and registered request
module cv32e40p_irq_arbiter #(
  parameter int                 NUM_IRQ  = 32,
  parameter int                 PRIO_W   = 3,
  parameter logic [NUM_IRQ-1:0] IRQ_MASK = {NUM_IRQ{1'b1}},
  localparam int                ID_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IRQ-1:0]        irq_i,
  input  logic [NUM_IRQ-1:0]        irq_edge_i,
  input  logic [NUM_IRQ*PRIO_W-1:0] irq_prio_i,
  input  logic [NUM_IRQ-1:0]        mie_i,
  input  logic                      m_ie_i,
  input  logic [PRIO_W-1:0]         threshold_i,
  input  logic                      irq_ack_i,
  input  logic [ID_W-1:0]           irq_ack_id_i,
  output logic                      irq_req_o,
  output logic [ID_W-1:0]           irq_id_o,
  output logic [PRIO_W-1:0]         irq_prio_o,
  output logic [NUM_IRQ-1:0]        mip_o,
  output logic                      irq_wu_o
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_prev;
  logic               filled;
  logic [NUM_IRQ-1:0] edge_pend;
  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] edge_clr;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] cand;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;
  logic               req_n;

  // Input stage; on the first clock after reset irq_prev loads the same sample as
  // irq_q so a line already held high is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q    <= '0;
      irq_prev <= '0;
      filled   <= 1'b0;
    end else begin
      irq_q    <= irq_i & IRQ_MASK;
      irq_prev <= filled ? irq_q : (irq_i & IRQ_MASK);
      filled   <= 1'b1;
    end
  end

  // Decode the acknowledge into a per-line clear; IDs beyond the last line match nothing.
  always_comb begin
    edge_clr = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (irq_ack_i && (int'(irq_ack_id_i) == k)) begin
        edge_clr[k] = 1'b1;
      end
    end
  end

  assign edge_set = irq_q & ~irq_prev & irq_edge_i;

  // Sticky edge pending: a new edge beats a simultaneous ack, level-mode lines drop their bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_pend <= '0;
    end else begin
      edge_pend <= ((edge_pend & ~edge_clr) | edge_set) & irq_edge_i & IRQ_MASK;
    end
  end

  // The live edge term lets an edge show as pending in the same cycle it is detected.
  assign pend  = (irq_edge_i & (edge_pend | edge_set)) | (~irq_edge_i & irq_q);
  assign mip_o = pend;
  assign cand  = pend & mie_i & IRQ_MASK;

  // Pick the highest priority candidate; scanning upward with >= gives ties to the highest index.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    win_prio  = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (cand[k] && (!win_valid || (irq_prio_i[k*PRIO_W +: PRIO_W] >= win_prio))) begin
        win_valid = 1'b1;
        win_id    = ID_W'(k);
        win_prio  = irq_prio_i[k*PRIO_W +: PRIO_W];
      end
    end
  end

  assign req_n = win_valid && m_ie_i && (win_prio > threshold_i);

  // Register the arbitration result every cycle so the controller sees a clean timing path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_req_o  <= 1'b0;
      irq_id_o   <= '0;
      irq_prio_o <= '0;
    end else begin
      irq_req_o  <= req_n;
      irq_id_o   <= win_id;
      irq_prio_o <= win_prio;
    end
  end

  assign irq_wu_o = |(irq_i & mie_i & IRQ_MASK);

endmodule

// File: tb/tb_cv32e40p_irq_arbiter.sv
// tb/tb_cv32e40p_irq_arbiter.sv - randomized and directed self-checking bench for cv32e40p_irq_arbiter
module tb_cv32e40p_irq_arbiter;

  localparam int N  = 32;
  localparam int PW = 3;
  localparam logic [N-1:0] MASK = 32'hFFFF_FFEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance: 32 lines, line 4 masked off
  logic [N-1:0]    irq, edge_m, mie, mip;
  logic [N*PW-1:0] prio;
  logic            gie, ack, req;
  logic [PW-1:0]   thr, prio_o;
  logic [4:0]      ack_id, id_o;
  logic            wu;

  // single-line instance
  logic            a_irq, a_edge, a_mie, a_gie, a_ack, a_ack_id, a_req, a_id, a_mip, a_wu;
  logic [PW-1:0]   a_prio, a_thr, a_prio_o;

  // 64-line instance
  logic [63:0]     b_irq, b_edge, b_mie, b_mip;
  logic [64*PW-1:0] b_prio;
  logic            b_gie, b_ack, b_req, b_wu;
  logic [PW-1:0]   b_thr, b_prio_o;
  logic [5:0]      b_ack_id, b_id;

  cv32e40p_irq_arbiter #(.NUM_IRQ(N), .PRIO_W(PW), .IRQ_MASK(MASK)) u_dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_edge_i(edge_m), .irq_prio_i(prio),
    .mie_i(mie), .m_ie_i(gie), .threshold_i(thr), .irq_ack_i(ack), .irq_ack_id_i(ack_id),
    .irq_req_o(req), .irq_id_o(id_o), .irq_prio_o(prio_o), .mip_o(mip), .irq_wu_o(wu));

  cv32e40p_irq_arbiter #(.NUM_IRQ(1), .PRIO_W(PW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .irq_i(a_irq), .irq_edge_i(a_edge), .irq_prio_i(a_prio),
    .mie_i(a_mie), .m_ie_i(a_gie), .threshold_i(a_thr), .irq_ack_i(a_ack), .irq_ack_id_i(a_ack_id),
    .irq_req_o(a_req), .irq_id_o(a_id), .irq_prio_o(a_prio_o), .mip_o(a_mip), .irq_wu_o(a_wu));

  cv32e40p_irq_arbiter #(.NUM_IRQ(64), .PRIO_W(PW)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .irq_i(b_irq), .irq_edge_i(b_edge), .irq_prio_i(b_prio),
    .mie_i(b_mie), .m_ie_i(b_gie), .threshold_i(b_thr), .irq_ack_i(b_ack), .irq_ack_id_i(b_ack_id),
    .irq_req_o(b_req), .irq_id_o(b_id), .irq_prio_o(b_prio_o), .mip_o(b_mip), .irq_wu_o(b_wu));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-line view of the input as seen one and two clocks ago,
  // a sticky "edge seen and not yet taken" flag, and the expected registered outputs.
  logic [N-1:0] mask_v;
  bit  seen1[N], seen2[N], latched[N];
  bit  primed;
  int  exp_req, exp_id, exp_prio;

  function automatic bit visible(int k);
    if (edge_m[k]) return latched[k] || (seen1[k] && !seen2[k]);
    return seen1[k];
  endfunction

  function automatic logic [N-1:0] exp_mip();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = visible(k);
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      seen1[k] = 0; seen2[k] = 0; latched[k] = 0;
    end
    primed = 0; exp_req = 0; exp_id = 0; exp_prio = 0;
  endtask

  task automatic model_edge();
    bit found;
    int wk, wp;
    bit now_in;
    found = 0; wk = 0; wp = 0;
    // search from the top priority downward, and within it from the top line downward
    for (int p = (1 << PW) - 1; p >= 0; p--) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (!found && visible(k) && mie[k] && mask_v[k] && int'(prio[k*PW +: PW]) == p) begin
          found = 1; wk = k; wp = p;
        end
      end
    end
    exp_req  = (found && gie && wp > int'(thr)) ? 1 : 0;
    exp_id   = wk;
    exp_prio = wp;
    for (int k = 0; k < N; k++)
      latched[k] = edge_m[k] && ((seen1[k] && !seen2[k]) ||
                                 (latched[k] && !(ack && int'(ack_id) == k)));
    for (int k = 0; k < N; k++) begin
      now_in   = irq[k] && mask_v[k];
      seen2[k] = primed ? seen1[k] : now_in;
      seen1[k] = now_in;
    end
    primed = 1;
  endtask

  // One clock: advance the model at the rising edge, compare the main instance at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(); else model_clear();
    @(negedge clk);
    chk("req",  64'(req),    64'(exp_req));
    chk("id",   64'(id_o),   64'(exp_id));
    chk("prio", 64'(prio_o), 64'(exp_prio));
    chk("mip",  64'(mip),    64'(exp_mip()));
    chk("wu",   64'(wu),     64'(|(irq & mie & mask_v)));
  endtask

  task automatic set_prio(input int k, input int p);
    prio[k*PW +: PW] = PW'(p);
  endtask

  initial begin
    mask_v = MASK;
    rst_n = 1'b0;
    irq = '0; edge_m = '0; mie = '1; prio = '0; gie = 1'b1; thr = '0; ack = 1'b0; ack_id = '0;
    a_irq = 0; a_edge = 0; a_mie = 1; a_gie = 1; a_thr = '0; a_ack = 0; a_ack_id = 0; a_prio = '0;
    b_irq = '0; b_edge = '0; b_mie = '1; b_gie = 1; b_thr = '0; b_ack = 0; b_ack_id = '0; b_prio = '0;
    model_clear();
    step(); step();
    chk("rst_req", 64'(req), 64'(0));
    chk("rst_mip", 64'(mip), 64'(0));
    rst_n = 1'b1;
    step();

    // priorities and ties
    set_prio(3, 5); set_prio(20, 2);
    irq[3] = 1; irq[20] = 1;
    step();
    chk("t1_req_early", 64'(req), 64'(0));
    step();
    chk("t1_req",  64'(req),    64'(1));
    chk("t1_id",   64'(id_o),   64'(3));
    chk("t1_prio", 64'(prio_o), 64'(5));
    set_prio(3, 2);
    step();
    chk("t1_tie_id", 64'(id_o), 64'(20));
    irq = '0; step(); step();

    // edge set, hold and ack
    edge_m[7] = 1; set_prio(7, 1);
    irq[7] = 1; step();
    chk("t2_mip_1cyc", 64'(mip[7]), 64'(1));
    irq[7] = 0; step(); step();
    chk("t2_mip_hold", 64'(mip[7]), 64'(1));
    chk("t2_req",      64'(req),    64'(1));
    chk("t2_id",       64'(id_o),   64'(7));
    ack = 1; ack_id = 5'd7; step();
    ack = 0;
    chk("t2_mip_clr",  64'(mip[7]), 64'(0));
    chk("t2_req_hold", 64'(req),    64'(1));
    step();
    chk("t2_req_drop", 64'(req),    64'(0));

    // ack collides with a new edge
    irq[7] = 1; step();
    ack = 1; ack_id = 5'd7; step();
    ack = 0;
    chk("t3_mip_kept", 64'(mip[7]), 64'(1));
    irq[7] = 0; ack = 1; step();
    ack = 0; step(); step();
    chk("t3_cleared", 64'(mip[7]), 64'(0));

    // threshold and global gating
    set_prio(9, 3); irq[9] = 1; thr = 3'd3;
    step(); step();
    chk("t4_thr_eq", 64'(req), 64'(0));
    thr = 3'd2; step();
    chk("t4_thr_lo", 64'(req), 64'(1));
    gie = 0; step();
    chk("t4_gie_req", 64'(req), 64'(0));
    chk("t4_gie_wu",  64'(wu),  64'(1));
    irq = '0; gie = 1; thr = '0; step();

    // masked line
    irq[4] = 1; set_prio(4, 7); step(); step();
    chk("t5_mask_mip", 64'(mip[4]), 64'(0));
    chk("t5_mask_req", 64'(req),    64'(0));
    chk("t5_mask_wu",  64'(wu),     64'(0));
    irq[4] = 0;

    // reset with an edge pending, then a line held high across reset release
    irq[7] = 1; step(); irq[7] = 0; step(); step();
    chk("t5_pend_pre", 64'(mip[7]), 64'(1));
    rst_n = 0; #1;
    model_clear();
    chk("t5_rst_req",  64'(req),  64'(0));
    chk("t5_rst_id",   64'(id_o), 64'(0));
    chk("t5_rst_mip",  64'(mip),  64'(0));
    irq[7] = 1;
    step();
    rst_n = 1;
    step(); step();
    chk("t5_noedge_mip", 64'(mip[7]), 64'(0));
    chk("t5_noedge_req", 64'(req),    64'(0));
    irq = '0; edge_m = '0; step();

    // randomized run
    for (int c = 0; c < 1500; c++) begin
      irq = irq ^ ($urandom & $urandom & $urandom);
      if (c % 50 == 0) edge_m = $urandom;
      if (c % 20 == 0) for (int k = 0; k < N; k++) set_prio(k, int'($urandom_range(0, 7)));
      if (c % 30 == 0) mie = $urandom | $urandom;
      if (c % 10 == 0) thr = PW'($urandom_range(0, 3));
      gie = ($urandom_range(0, 9) != 0);
      ack = ($urandom_range(0, 3) == 0);
      ack_id = ($urandom_range(0, 1) == 0) ? 5'(exp_id) : 5'($urandom);
      step();
    end
    irq = '0; ack = 0; step();

    // single-line variant
    a_irq = 1; a_prio = 3'd5; step();
    chk("n1_req_early", 64'(a_req), 64'(0));
    chk("n1_wu", 64'(a_wu), 64'(1));
    step();
    chk("n1_req",  64'(a_req),    64'(1));
    chk("n1_id",   64'(a_id),     64'(0));
    chk("n1_prio", 64'(a_prio_o), 64'(5));
    a_prio = 3'd0; step();
    chk("n1_prio0_req", 64'(a_req), 64'(0));

    // 64-line variant
    b_prio[3*PW +: PW] = 3'd5; b_prio[63*PW +: PW] = 3'd2;
    b_irq[3] = 1; b_irq[63] = 1; step();
    chk("n64_req_early", 64'(b_req), 64'(0));
    step();
    chk("n64_req",  64'(b_req),    64'(1));
    chk("n64_id",   64'(b_id),     64'(3));
    chk("n64_prio", 64'(b_prio_o), 64'(5));
    b_prio[3*PW +: PW] = 3'd2; step();
    chk("n64_tie_id",   64'(b_id),     64'(63));
    chk("n64_tie_prio", 64'(b_prio_o), 64'(2));
    chk("n64_mip", b_mip, 64'h8000_0000_0000_0008);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
